// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: multicycle RV32I control FSM sequencing the shared ALU, register file and unified memory.
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             pc_update, branch;

    assign retired_count = retired_q;

    // Outputs decode as FETCH while in reset; strobes are then masked below.
    always_comb begin
        state_d       = FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        instr_retired = 1'b0;
        case (rst_n ? state_q : FETCH)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BEQ;
                    7'b1101111:             state_d = JAL;
                    default:                illegal_instr = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write     = 1'b1;
                instr_retired = mem_ready;
                state_d       = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            BEQ: begin
                alu_src_a     = 2'b10;
                alu_op        = 2'b01;
                branch        = 1'b1;
                instr_retired = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase
        pc_write = pc_update | (branch & zero);
        if (!rst_n) begin
            pc_write      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
            instr_retired = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_q + CNT_W'(instr_retired);
        end
    end
endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sequences the shared ALU, register file, instruction register and unified instruction/data memory over several cycles per instruction.
- Drives the 2-bit alu_op into alu_control_unit and selects the ALU operand and result muxes.
- Supports lw, sw, R-type, I-type ALU, beq and jal, with a memory ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps at 2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- op  input  7  opcode field, instr[6:0], from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register and old-PC register enable.
- result_src  output  2  result mux: 00 = ALU out register, 01 = data register, 10 = ALU result.
- alu_src_a  output  2  ALU A: 00 = PC, 01 = old PC, 10 = rs1 data.
- alu_src_b  output  2  ALU B: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- alu_op  output  2  to alu_control_unit: 00 = add, 01 = sub, 10 = decode funct3/funct7.
- reg_write  output  1  register file write enable.
- illegal_instr  output  1  one-cycle pulse, unsupported opcode seen in DECODE.
- instr_retired  output  1  one-cycle pulse on the final cycle of each instruction.
- retired_count  output  CNT_W  count of retired instructions.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst_n low at an edge: state <= FETCH, retired_count <= 0. This applies mid-instruction, including while waiting on mem_ready.
  - While rst_n is low, pc_write, mem_write, ir_write, reg_write, illegal_instr and instr_retired are forced to 0.
  - While rst_n is low, the remaining outputs take their FETCH values.
- Outputs:
  - Moore-decoded from state, except the items gated by mem_ready and zero.
  - pc_write = pc_update | (branch & zero).
  - Any output not listed for a state is 0.
- State encoding (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 are unused and go to FETCH next cycle with no side effects.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other op: illegal_instr=1 for this cycle, next state FETCH, not counted as retired.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_retired=1. Next FETCH.
- MEMWRITE:
  - adr_src=1, mem_write=1, held continuously until mem_ready=1.
  - On the mem_ready cycle: instr_retired=1, next FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_retired=1. Next FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_retired=1.
  - PC is loaded only if zero=1. Next FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
  - Next ALUWB, where rd <= old PC + 4.
- Latency with mem_ready tied high, counted from FETCH entry to the next FETCH entry: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles. Each cycle mem_ready is low adds one cycle.
- retired_count:
  - Increments by 1 on each cycle instr_retired=1.
  - Wraps from 2^CNT_W-1 to 0.
  - Reset has priority over increment.

Test Plan:
- Reset held 3 cycles mid-MEMWRITE with mem_ready=0 -> mem_write=0 during reset; FETCH next cycle; retired_count=0.
- mem_ready=1, op=0110011 -> states FETCH, DECODE, EXECR, ALUWB; alu_op=10 in EXECR; reg_write=1 only in ALUWB; retired_count=1 after 4 cycles.
- op=0000011, mem_ready low 2 cycles in MEMREAD -> adr_src=1 for 3 cycles, then MEMWB with result_src=01 and reg_write=1; total 7 cycles.
- op=1100011 with zero=1, then repeat with zero=0 -> pc_write=1 in BEQ only for zero=1; alu_op=01 in both; instr_retired pulses both times.
- op=1101111 -> JAL asserts pc_write=1 with alu_src_a=01, alu_src_b=10; ALUWB writes register; 4 cycles total.
- op=1111111 -> illegal_instr pulses 1 cycle in DECODE, returns to FETCH, retired_count unchanged. With CNT_W=4, 16 retirements -> count wraps to 0.
